// File: rtl/sseg_pkg.sv
// Shared constants, glyph table and FSM encoding for the signed
// seven-segment formatter. Segments are active-low, bit0=a .. bit6=g.
package sseg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FORMAT = 2'd2
   } state_t;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_sseg.sv
// One display position: BCD nibble plus blank/minus flags to
// active-low segments. Ports: bcd, blank, minus in; seg out.
module bcd_digit_sseg
   import sseg_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   input  logic       minus,
   output logic [6:0] seg
);

   // minus wins over blank so the sign can sit in a blanked slot
   assign seg = minus ? SEG_MINUS :
                blank ? SEG_BLANK : seg7(bcd);

endmodule

// File: rtl/sseg_signed_display.sv
// Serial double-dabble signed formatter to DIGITS seven-seg digits.
// Ports: clk, rst, load, value in; busy, done, ovf, segs out.
// Option: define SSEG_OVERFLOW_EN to show all dashes on overflow.
module sseg_signed_display
   import sseg_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4,
   parameter bit SIGNED = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [WIDTH-1:0]    value,
   output logic                busy,
   output logic                done,
   output logic                ovf,
   output logic [7*DIGITS-1:0] segs
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [63:0] LIM_POS = pow10(DIGITS);
   localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1);

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic neg_q, neg_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [BW-1:0] bcd_q, bcd_d, adj;
   logic [7*DIGITS-1:0] segs_q, segs_d, fmt_segs;
   logic done_q, done_d;
   logic ovf_q, ovf_d, ovf_now;
   logic [DIGITS-1:0] blank_v, minus_v;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Blanking and sign placement work on the raw BCD digits, so a
   // truncated negative result keeps its zeros and the sign takes
   // the leftmost slot.
   always_comb begin
      logic seen;
      int top;
      int mpos;
      blank_v = '0;
      minus_v = '0;
      seen = 1'b0;
      top = 0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         seen = seen | (bcd_q[4*i +: 4] != 4'd0);
         if (i != 0) begin
            blank_v[i] = !seen;
         end
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) begin
            top = i;
         end
      end
      mpos = (top == DIGITS - 1) ? top : top + 1;
      for (int i = 0; i < DIGITS; i++) begin
         minus_v[i] = neg_q && (i == mpos);
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_sseg u_dig (
         .bcd   (bcd_q[4*g +: 4]),
         .blank (blank_v[g]),
         .minus (minus_v[g]),
         .seg   (fmt_segs[7*g +: 7])
      );
   end

   assign ovf_now = 64'(mag_q) >= (neg_q ? LIM_NEG : LIM_POS);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      mag_d   = mag_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      segs_d  = segs_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (load) begin
               neg_d = SIGNED & value[WIDTH-1];
               // -2^(WIDTH-1) maps onto itself, read as unsigned
               mag_d = neg_d ? (~value + WIDTH'(1)) : value;
               sh_d = mag_d;
               bcd_d = '0;
               cnt_d = CW'(WIDTH - 1);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bcd_d = {adj[BW-2:0], sh_q[WIDTH-1]};
            sh_d = {sh_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = ST_FORMAT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FORMAT: begin
            ovf_d = ovf_now;
`ifdef SSEG_OVERFLOW_EN
            segs_d = ovf_now ? {DIGITS{SEG_MINUS}} : fmt_segs;
`else
            segs_d = fmt_segs;
`endif
            done_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         mag_q   <= '0;
         sh_q    <= '0;
         bcd_q   <= '0;
         segs_q  <= {DIGITS{SEG_BLANK}};
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         mag_q   <= mag_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         segs_q  <= segs_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign ovf  = ovf_q;
   assign segs = segs_q;

endmodule

// File: tb/tb_sseg_signed_display.sv
// Bench for sseg_signed_display: signed and unsigned instances
// share stimulus and are compared against an arithmetic model.
module tb_sseg_signed_display;

`ifdef SSEG_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   localparam logic [6:0] GLY [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   logic clk;
   logic rst;
   logic load;
   logic [7:0] value;
   logic busy_s, done_s, ovf_s;
   logic busy_u, done_u, ovf_u;
   logic [20:0] segs_s, segs_u;

   int checks = 0;
   int failures = 0;

   sseg_signed_display #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_dut_s (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (value),
      .busy  (busy_s),
      .done  (done_s),
      .ovf   (ovf_s),
      .segs  (segs_s)
   );

   sseg_signed_display #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) u_dut_u (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (value),
      .busy  (busy_u),
      .done  (done_u),
      .ovf   (ovf_u),
      .segs  (segs_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decimal formatting straight from the display rules.
   function automatic void model(input logic [7:0] v, input bit sgn,
                                 output logic [20:0] s, output logic o);
      int m, top, mpos, d;
      bit n;
      n = sgn && v[7];
      m = n ? 256 - int'(v) : int'(v);
      o = (m >= (n ? 100 : 1000));
      s = '0;
      if (o && OVF_EN) begin
         s = {3{7'h3F}};
      end else begin
         top = 0;
         for (int i = 0; i < 3; i++) begin
            if ((m / (10 ** i)) % 10 != 0) top = i;
         end
         mpos = (top < 2) ? top + 1 : 2;
         for (int i = 0; i < 3; i++) begin
            d = (m / (10 ** i)) % 10;
            if (n && i == mpos) s[7*i +: 7] = 7'h3F;
            else if (i > top) s[7*i +: 7] = 7'h7F;
            else s[7*i +: 7] = GLY[d];
         end
      end
   endfunction

   task automatic convert(input logic [7:0] v, input bit hold);
      logic [20:0] es, eu;
      logic eos, eou;
      int lat, bcnt;
      bit got;
      model(v, 1'b1, es, eos);
      model(v, 1'b0, eu, eou);
      load = 1'b1;
      value = v;
      @(posedge clk); #1;
      if (!hold) load = 1'b0;
      else value = 8'($urandom);
      bcnt = 0;
      lat = 0;
      got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
         if (busy_s) bcnt++;
         @(posedge clk); #1;
         lat = k;
         if (done_s) got = 1'b1;
         else if (hold) value = 8'($urandom);
      end
      load = 1'b0;
      chk("done_seen", 32'(got), 32'd1);
      chk("latency", lat, 32'd9);
      chk("busy_cycles", bcnt, 32'd9);
      chk("done_u", 32'(done_u), 32'd1);
      chk("segs_s", 32'(segs_s), 32'(es));
      chk("ovf_s", 32'(ovf_s), 32'(eos));
      chk("segs_u", 32'(segs_u), 32'(eu));
      chk("ovf_u", 32'(ovf_u), 32'(eou));
      chk("busy_at_done", 32'(busy_s), 32'd0);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done_s), 32'd0);
      chk("busy_idle", 32'(busy_s | busy_u), 32'd0);
      chk("segs_hold", 32'(segs_s), 32'(es));
   endtask

   initial begin
      bit seen_done;
      rst = 1'b1;
      load = 1'b0;
      value = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_segs", 32'(segs_s), 32'h1FFFFF);
      chk("rst_busy", 32'(busy_s), 32'd0);
      chk("rst_done", 32'(done_s), 32'd0);
      chk("rst_ovf", 32'(ovf_s), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      convert(8'd0, 1'b0);
      chk("zero_glyph", 32'(segs_s), 32'({7'h7F, 7'h7F, 7'h40}));
      convert(8'hF9, 1'b1);
      chk("m7_glyph", 32'(segs_s), 32'({7'h7F, 7'h3F, 7'h78}));
      convert(8'h9D, 1'b0);
      chk("m99_glyph", 32'(segs_s), 32'({7'h3F, 7'h10, 7'h10}));
      convert(8'h9C, 1'b0);
      chk("m100_ovf", 32'(ovf_s), 32'd1);
      if (OVF_EN)
         chk("m100_dash", 32'(segs_s), 32'({3{7'h3F}}));
      else
         chk("m100_trunc", 32'(segs_s), 32'({7'h3F, 7'h40, 7'h40}));
      convert(8'h80, 1'b0);
      chk("m128_ovf", 32'(ovf_s), 32'd1);
      chk("u128_glyph", 32'(segs_u), 32'({7'h79, 7'h24, 7'h00}));
      chk("u128_ovf", 32'(ovf_u), 32'd0);
      convert(8'd255, 1'b0);
      convert(8'd127, 1'b0);

      for (int r = 0; r < 25; r++) begin
         convert(8'($urandom), r[0]);
      end

      load = 1'b1;
      value = 8'hF9;
      @(posedge clk); #1;
      load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_segs", 32'(segs_s), 32'h1FFFFF);
      chk("abort_busy", 32'(busy_s), 32'd0);
      chk("abort_done", 32'(done_s), 32'd0);
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done_s) seen_done = 1'b1;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      convert(8'hFB, 1'b0);
      convert(8'd42, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
